wb_arbiter: RTL and testbench

- Shares the single register-file write port among the five functional units: ALU, MEM, MUL, DIV and JUMP.
- Each FU pulses `done` for one cycle with its destination register and result. The arbiter captures the pulse and grants the write port round-robin.
- Each FU has a one-entry holding buffer, so simultaneous completions are serialised without loss.
- It sits between the FU outputs and the regfile write port. It replaces the single-FU write_sel/reg_write path and lets the control unit keep several FUs in flight.

---
 rtl/wb_arbiter.sv | 153 +++++++++++++++
 tb/tb_wb_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//
// Shares the single register-file write port among NUM_FU functional units
// (0=ALU, 1=MEM, 2=MUL, 3=DIV, 4=JUMP). Each FU owns a one-entry holding
// buffer, so simultaneous completions are serialised without loss. The write
// port is granted round-robin, and the write itself is registered.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   fu_done    one-cycle completion pulse per FU
//   fu_wen     completing instruction writes back
//   fu_rd      packed destination registers, FU i in [5i+4:5i]
//   fu_data    packed results, FU i in [DW*i+DW-1:DW*i]
//   fu_full    buffer i occupied (combinational from buffer state)
//   pend_rd    one-hot OR of rd of every valid buffer entry, bit 0 always 0
//   reg_write  registered regfile write enable
//   rd_ctrl    registered write address
//   wb_data    registered write data
//   wb_src     registered index of the granted FU
//   overflow   sticky protocol-error flag
//
// Handshake: there is no ready signal towards the FUs. A completion is taken
// when fu_done[i] & fu_wen[i] & (rd != 0) in a cycle. The producer must not
// complete on FU i while fu_full[i] is set unless that buffer is being
// granted in the same cycle; a completion that arrives while the buffer is
// held and not granted is dropped and raises overflow.
// ---------------------------------------------------------------------------
module wb_arbiter #(
  parameter int NUM_FU = 5,
  parameter int DW     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_FU-1:0]    fu_done,
  input  logic [NUM_FU-1:0]    fu_wen,
  input  logic [5*NUM_FU-1:0]  fu_rd,
  input  logic [DW*NUM_FU-1:0] fu_data,
  output logic [NUM_FU-1:0]    fu_full,
  output logic [31:0]          pend_rd,
  output logic                 reg_write,
  output logic [4:0]           rd_ctrl,
  output logic [DW-1:0]        wb_data,
  output logic [2:0]           wb_src,
  output logic                 overflow
);

  localparam int IW = 3;

  logic [NUM_FU-1:0] buf_v;
  logic [4:0]        buf_rd   [NUM_FU];
  logic [DW-1:0]     buf_data [NUM_FU];

  logic [4:0]        in_rd    [NUM_FU];
  logic [DW-1:0]     in_data  [NUM_FU];
  logic [4:0]        pay_rd   [NUM_FU];
  logic [DW-1:0]     pay_data [NUM_FU];
  logic [NUM_FU-1:0] live;
  logic [NUM_FU-1:0] req;

  logic [IW-1:0]     last;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_any;
  logic [NUM_FU-1:0] gnt_oh;
  int                cand;

  // Unpack inputs and form per-FU requests. A buffered entry takes priority
  // over the live input so the older result is always written first.
  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
    assign in_rd[g]    = fu_rd[5*g +: 5];
    assign in_data[g]  = fu_data[DW*g +: DW];
    assign live[g]     = fu_done[g] & fu_wen[g] & (in_rd[g] != 5'd0);
    assign req[g]      = buf_v[g] | live[g];
    assign pay_rd[g]   = buf_v[g] ? buf_rd[g]   : in_rd[g];
    assign pay_data[g] = buf_v[g] ? buf_data[g] : in_data[g];
  end

  // Round-robin search starting just after the last granted FU.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    cand    = 0;
    for (int k = 1; k <= NUM_FU; k++) begin
      cand = int'(last) + k;
      if (cand >= NUM_FU) cand = cand - NUM_FU;
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(cand);
      end
    end
    if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
  end

  assign fu_full = buf_v;

  always_comb begin
    pend_rd = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (buf_v[i]) pend_rd[buf_rd[i]] = 1'b1;
    end
    pend_rd[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write <= 1'b0;
      rd_ctrl   <= '0;
      wb_data   <= '0;
      wb_src    <= '0;
      overflow  <= 1'b0;
      last      <= IW'(NUM_FU - 1);
      buf_v     <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        buf_rd[i]   <= '0;
        buf_data[i] <= '0;
      end
    end else begin
      reg_write <= gnt_any;
      if (gnt_any) begin
        rd_ctrl <= pay_rd[gnt_idx];
        wb_data <= pay_data[gnt_idx];
        wb_src  <= gnt_idx;
        last    <= gnt_idx;
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if (gnt_oh[i]) begin
          // Granted from the buffer: refill with a new completion if one
          // arrived, otherwise free it. A granted bypass leaves it empty.
          if (buf_v[i]) begin
            if (live[i]) begin
              buf_rd[i]   <= in_rd[i];
              buf_data[i] <= in_data[i];
            end else begin
              buf_v[i] <= 1'b0;
            end
          end
        end else if (live[i]) begin
          if (!buf_v[i]) begin
            buf_v[i]    <= 1'b1;
            buf_rd[i]   <= in_rd[i];
            buf_data[i] <= in_data[i];
          end else begin
            // Held entry not draining: keep it and drop the newcomer.
            overflow <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  localparam int NUM_FU = 5;
  localparam int DW     = 32;

  // ---------------- clock / reset ----------------
  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NUM_FU-1:0]    fu_done = '0;
  logic [NUM_FU-1:0]    fu_wen  = '0;
  logic [5*NUM_FU-1:0]  fu_rd   = '0;
  logic [DW*NUM_FU-1:0] fu_data = '0;
  logic [NUM_FU-1:0]    fu_full;
  logic [31:0]          pend_rd;
  logic                 reg_write;
  logic [4:0]           rd_ctrl;
  logic [DW-1:0]        wb_data;
  logic [2:0]           wb_src;
  logic                 overflow;

  always #5 clk = ~clk;

  wb_arbiter #(.NUM_FU(NUM_FU), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .fu_done   (fu_done),
    .fu_wen    (fu_wen),
    .fu_rd     (fu_rd),
    .fu_data   (fu_data),
    .fu_full   (fu_full),
    .pend_rd   (pend_rd),
    .reg_write (reg_write),
    .rd_ctrl   (rd_ctrl),
    .wb_data   (wb_data),
    .wb_src    (wb_src),
    .overflow  (overflow)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each FU keeps a queue of results waiting for the port. Completions are
  // appended, the round-robin winner pops its oldest entry, and anything
  // beyond one leftover entry is a lost result (overflow).
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq [NUM_FU][$];
  int          m_last;
  logic        m_rw;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [2:0]  m_src;
  logic        m_ovf;

  task automatic model_reset();
    for (int i = 0; i < NUM_FU; i++) mq[i].delete();
    m_last = NUM_FU - 1;
    m_rw   = 1'b0;
    m_rd   = '0;
    m_data = '0;
    m_src  = '0;
    m_ovf  = 1'b0;
  endtask

  function automatic int model_pick(input logic [NUM_FU-1:0] mask);
    int g = -1;
    for (int k = 1; k <= NUM_FU; k++) begin
      int j = (m_last + k) % NUM_FU;
      if (g < 0 && mask[j]) g = j;
    end
    return g;
  endfunction

  task automatic model_cycle(input logic [4:0] done, input logic [4:0] wen,
                             input logic [24:0] rd, input logic [159:0] data);
    ent_t e;
    logic [NUM_FU-1:0] mask;
    int g;
    for (int i = 0; i < NUM_FU; i++) begin
      if (done[i] && wen[i] && rd[5*i +: 5] != 5'd0) begin
        e.rd   = rd[5*i +: 5];
        e.data = data[32*i +: 32];
        mq[i].push_back(e);
      end
    end
    mask = '0;
    for (int i = 0; i < NUM_FU; i++) mask[i] = (mq[i].size() > 0);
    g = model_pick(mask);
    if (g >= 0) begin
      e      = mq[g].pop_front();
      m_rw   = 1'b1;
      m_rd   = e.rd;
      m_data = e.data;
      m_src  = 3'(g);
      m_last = g;
    end else begin
      m_rw = 1'b0;
    end
    for (int i = 0; i < NUM_FU; i++) begin
      if (mq[i].size() > 1) begin
        void'(mq[i].pop_back());
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic model_check();
    logic [4:0]  full = '0;
    logic [31:0] pend = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      full[i] = (mq[i].size() > 0);
      foreach (mq[i][k]) pend = pend | (32'd1 << mq[i][k].rd);
    end
    pend[0] = 1'b0;
    chk("m_reg_write", 32'(reg_write), 32'(m_rw));
    chk("m_rd_ctrl",   32'(rd_ctrl),   32'(m_rd));
    chk("m_wb_data",   wb_data,        m_data);
    chk("m_wb_src",    32'(wb_src),    32'(m_src));
    chk("m_fu_full",   32'(fu_full),   32'(full));
    chk("m_pend_rd",   pend_rd,        pend);
    chk("m_overflow",  32'(overflow),  32'(m_ovf));
  endtask

  // ---------------- driver tasks ----------------
  // Applies one cycle of inputs, advances the model, and compares just after
  // the rising edge.
  task automatic step(input logic [4:0] done, input logic [4:0] wen,
                      input logic [24:0] rd, input logic [159:0] data);
    fu_done = done;
    fu_wen  = wen;
    fu_rd   = rd;
    fu_data = data;
    model_cycle(done, wen, rd, data);
    @(posedge clk);
    #1;
    model_check();
    fu_done = '0;
    fu_wen  = '0;
    fu_rd   = '0;
    fu_data = '0;
  endtask

  task automatic idle();
    step(5'b0, 5'b0, 25'b0, 160'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_reg_write"}, 32'(reg_write), 32'd0);
    chk({tag, "_rd_ctrl"},   32'(rd_ctrl),   32'd0);
    chk({tag, "_wb_data"},   wb_data,        32'd0);
    chk({tag, "_wb_src"},    32'(wb_src),    32'd0);
    chk({tag, "_fu_full"},   32'(fu_full),   32'd0);
    chk({tag, "_pend_rd"},   pend_rd,        32'd0);
    chk({tag, "_overflow"},  32'(overflow),  32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("rst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [4:0]   done;
    logic [4:0]   wen;
    logic [24:0]  rd;
    logic [159:0] data;
    logic         rw;
    logic [4:0]   rdc;
    logic [31:0]  wd;
    logic [2:0]   src;
    logic [4:0]   full;
    logic [31:0]  pend;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] done, input logic [4:0] wen,
                              input logic [24:0] rd, input logic [159:0] data,
                              input logic rw, input logic [4:0] rdc,
                              input logic [31:0] wd, input logic [2:0] src,
                              input logic [4:0] full, input logic [31:0] pend);
    vec_t v;
    v.done = done; v.wen = wen; v.rd = rd; v.data = data;
    v.rw = rw; v.rdc = rdc; v.wd = wd; v.src = src; v.full = full; v.pend = pend;
    return v;
  endfunction

  vec_t tbl [9];

  // ---------------- main sequence ----------------
  initial begin
    logic [4:0] d;
    logic [4:0] w;
    logic [24:0] r;
    logic [159:0] x;
    int g;

    model_reset();
    #12;
    check_all_zero("por");
    @(negedge clk);
    rst = 1'b1;

    // Three simultaneous completions after reset, then single and non-live.
    tbl[0] = mk(5'b01101, 5'b01101, {5'd0, 5'd3, 5'd2, 5'd0, 5'd1},
                {32'h0, 32'h33, 32'h22, 32'h0, 32'h11},
                1'b1, 5'd1, 32'h11, 3'd0, 5'b01100, 32'h0000000C);
    tbl[1] = mk(5'b0, 5'b0, 25'b0, 160'b0, 1'b1, 5'd2, 32'h22, 3'd2, 5'b01000, 32'h00000008);
    tbl[2] = mk(5'b0, 5'b0, 25'b0, 160'b0, 1'b1, 5'd3, 32'h33, 3'd3, 5'b00000, 32'h0);
    tbl[3] = mk(5'b0, 5'b0, 25'b0, 160'b0, 1'b0, 5'd3, 32'h33, 3'd3, 5'b00000, 32'h0);
    tbl[4] = mk(5'b00001, 5'b00001, {20'd0, 5'd5}, {128'h0, 32'h00001234},
                1'b1, 5'd5, 32'h1234, 3'd0, 5'b0, 32'h0);
    tbl[5] = mk(5'b0, 5'b0, 25'b0, 160'b0, 1'b0, 5'd5, 32'h1234, 3'd0, 5'b0, 32'h0);
    tbl[6] = mk(5'b00001, 5'b00000, {20'd0, 5'd6}, {128'h0, 32'h66},
                1'b0, 5'd5, 32'h1234, 3'd0, 5'b0, 32'h0);
    tbl[7] = mk(5'b00010, 5'b00010, 25'b0, {96'h0, 32'h77, 32'h0},
                1'b0, 5'd5, 32'h1234, 3'd0, 5'b0, 32'h0);
    tbl[8] = mk(5'b10000, 5'b10000, {5'd9, 20'd0}, {32'h99, 128'h0},
                1'b1, 5'd9, 32'h99, 3'd4, 5'b0, 32'h0);

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].done, tbl[i].wen, tbl[i].rd, tbl[i].data);
      chk($sformatf("t%0d_reg_write", i), 32'(reg_write), 32'(tbl[i].rw));
      chk($sformatf("t%0d_rd_ctrl", i),   32'(rd_ctrl),   32'(tbl[i].rdc));
      chk($sformatf("t%0d_wb_data", i),   wb_data,        tbl[i].wd);
      chk($sformatf("t%0d_wb_src", i),    32'(wb_src),    32'(tbl[i].src));
      chk($sformatf("t%0d_fu_full", i),   32'(fu_full),   32'(tbl[i].full));
      chk($sformatf("t%0d_pend_rd", i),   pend_rd,        tbl[i].pend);
      chk($sformatf("t%0d_overflow", i),  32'(overflow),  32'd0);
    end

    // ALU and MEM complete whenever their buffer is free or being granted.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      g = model_pick(5'b00011);
      d = '0;
      for (int i = 0; i < 2; i++) d[i] = (mq[i].size() == 0) || (g == i);
      r = {15'd0, 5'd2, 5'd1};
      x = {96'h0, 32'hB000 + 32'(k), 32'hA000 + 32'(k)};
      step(d, d, r, x);
      chk($sformatf("alt%0d_wb_src", k),   32'(wb_src),    32'(k % 2));
      chk($sformatf("alt%0d_reg_write", k), 32'(reg_write), 32'd1);
      chk($sformatf("alt%0d_overflow", k), 32'(overflow),  32'd0);
    end

    // MUL held behind ALU receives a second completion.
    do_reset();
    step(5'b00100, 5'b00100, {10'd0, 5'd10, 10'd0}, {64'h0, 32'hA0, 64'h0});
    step(5'b01100, 5'b01100, {5'd0, 5'd3, 5'd2, 10'd0}, {32'h0, 32'h33, 32'h22, 64'h0});
    chk("ov_div_src", 32'(wb_src), 32'd3);
    step(5'b00101, 5'b00101, {10'd0, 5'd7, 5'd0, 5'd1}, {64'h0, 32'h77, 32'h0, 32'h11});
    chk("ov_alu_src", 32'(wb_src),   32'd0);
    chk("ov_set",     32'(overflow), 32'd1);
    idle();
    chk("ov_mul_rd",   32'(rd_ctrl),  32'd2);
    chk("ov_mul_data", wb_data,       32'h22);
    chk("ov_sticky1",  32'(overflow), 32'd1);
    idle();
    chk("ov_sticky2",  32'(overflow), 32'd1);
    chk("ov_drained",  32'(fu_full),  32'd0);

    // Asynchronous reset mid-cycle with occupied buffers and a live write.
    do_reset();
    step(5'b01000, 5'b01000, {5'd0, 5'd3, 15'd0}, {32'h0, 32'h33, 96'h0});
    step(5'b10111, 5'b10111, {5'd8, 5'd0, 5'd6, 5'd5, 5'd4},
         {32'h88, 32'h0, 32'h66, 32'h55, 32'h44});
    chk("ar_full_pre", 32'(fu_full),   32'b00111);
    chk("ar_rw_pre",   32'(reg_write), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("ar");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(5'b10010, 5'b10010, {5'd6, 10'd0, 5'd5, 5'd0}, {32'h64, 64'h0, 32'h15, 32'h0});
    chk("ar_first_src", 32'(wb_src), 32'd1);
    idle();
    chk("ar_second_src", 32'(wb_src), 32'd4);

    // Random traffic: protocol-respecting first, then unconstrained.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      d = '0; w = '0; r = '0; x = '0;
      for (int i = 0; i < NUM_FU; i++) begin
        if (c >= 300 || mq[i].size() == 0) d[i] = ($urandom_range(0, 99) < 40);
        w[i] = ($urandom_range(0, 3) != 0);
        r[5*i +: 5] = 5'($urandom_range(0, 31));
        x[32*i +: 32] = $urandom;
      end
      step(d, w, r, x);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
